me_best_match: RTL
==================

ME_BEST_MATCH -- requirements
Module: me_best_match

Interface
REQ-001 SHALL have parameter SAD_W, default 16, SAD width (16x16 block, max 65280).
REQ-002 SHALL have parameter MV_W, default 6, signed motion-vector component width (range -16..+16 used).
REQ-003 SHALL have parameter CNT_W, default 11, candidate counter width.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  begin new macroblock search, clears tracker.
REQ-007 sad_valid  in  1  candidate SAD present this cycle.
REQ-008 sad  in  SAD_W  candidate SAD, unsigned.
REQ-009 mv_x, mv_y  in  MV_W each  candidate displacement, two's complement.
REQ-010 search_done  in  1  one-cycle pulse from ME controller: scan finished.
REQ-011 thresh  in  SAD_W  early-stop threshold, unsigned.
REQ-012 busy  out  1  high in SEARCH and FLUSH.
REQ-013 early_stop  out  1  sticky: a best SAD <= thresh was recorded.
REQ-014 res_valid  out  1  result available; res_ready  in  1  consumer accepts.
REQ-015 best_sad  out  SAD_W; best_mv_x, best_mv_y  out  MV_W; cand_count  out  CNT_W; no_cand  out  1.

Function
REQ-016 SHALL implement FSM IDLE, SEARCH, FLUSH, OUT.
REQ-017 IDLE: start -> SEARCH; on that edge best_sad=all-ones, best mv=0, best cost=all-ones, cand_count=0, early_stop=0, stage-1 valid=0.
REQ-018 SEARCH: each sad_valid cycle SHALL capture sad, mv, cost=|mv_x|+|mv_y| into stage-1 register; stage 2 SHALL compare one cycle later.
REQ-019 Update rule: replace best when sad<best_sad, or sad==best_sad and cost<best_cost; otherwise keep (equal sad, equal cost -> first arrival wins).
REQ-020 cand_count SHALL increment per accepted sad_valid, saturating at 2^CNT_W-1.
REQ-021 search_done in SEARCH -> FLUSH; a sad_valid in the same cycle SHALL be accepted and counted.
REQ-022 FLUSH: one cycle to commit stage 1, then -> OUT unconditionally.
REQ-023 OUT: res_valid=1; all result outputs SHALL stay stable until res_valid&&res_ready, then -> IDLE.
REQ-024 Latency: search_done at cycle N -> res_valid high at N+2.
REQ-025 start in SEARCH SHALL restart (same clear as REQ-017, stays SEARCH); start in FLUSH or OUT SHALL be ignored.
REQ-026 sad_valid and search_done outside SEARCH SHALL be ignored.
REQ-027 early_stop SHALL set the cycle after a best update with new best_sad<=thresh; cleared only by start or reset.
REQ-028 no_cand SHALL equal (cand_count==0) while res_valid; then best_sad=all-ones, mv=0.
REQ-029 cost SHALL be computed at MV_W+1 bits unsigned; mv=-16 SHALL give |mv|=16.

Reset
REQ-030 rst_n low SHALL force IDLE, stage-1 valid=0, res_valid=0, busy=0, early_stop=0, no_cand=0, cand_count=0, best_sad=all-ones, best mv=0, asynchronously, any state, mid-search included.
REQ-031 After rst_n deassert, first start SHALL behave as REQ-017.

Structure
REQ-032 Package me_pkg SHALL hold SAD_W, MV_W, SAD_MAX constant and the FSM state enum, shared with the ME controller.
REQ-033 Comparison (REQ-019) SHALL be a combinational sub-module me_sad_cmp, inputs candidate/best sad and cost, output take_new.

Verification
REQ-034 start; SADs 900@(0,0), 400@(3,-2), 700@(1,1); search_done -> res_valid 2 cycles later, best_sad=400, mv=(3,-2), cand_count=3.
REQ-035 Ties: 500@(4,4), 500@(-1,0), 500@(0,1) -> best mv=(-1,0) (cost 1, first arrival wins over (0,1)).
REQ-036 thresh=256; SADs 1000 then 200 -> early_stop high the cycle after 200 is committed, stays high through OUT.
REQ-037 start then search_done with no sad_valid -> no_cand=1, best_sad=65535, mv=(0,0); res_ready held low 10 cycles -> outputs unchanged.
REQ-038 rst_n pulsed low mid-SEARCH after 5 SADs -> all outputs at reset values immediately; new search reports only post-reset candidates.
REQ-039 sad_valid with search_done same cycle, SAD 10@(-16,16) after best 50 -> best_sad=10, mv=(-16,16), cand_count includes it.

Source files
------------

// File: rtl/me_pkg.sv
// Constants and FSM state type shared by the best-match tracker and the ME controller.
package me_pkg;

  localparam int SAD_W = 16;
  localparam int MV_W  = 6;
  localparam int CNT_W = 11;

  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_OUT    = 2'd3
  } me_state_e;

endpackage

// File: rtl/me_sad_cmp.sv
// Candidate-versus-best decision: lower SAD wins; on equal SAD the lower MV cost wins.
module me_sad_cmp #(
  parameter int SAD_W  = 16,
  parameter int COST_W = 7
) (
  input  logic [SAD_W-1:0]  cand_sad,
  input  logic [SAD_W-1:0]  best_sad,
  input  logic [COST_W-1:0] cand_cost,
  input  logic [COST_W-1:0] best_cost,
  output logic              take_new
);

  // Equal SAD and equal cost keeps the incumbent, so the first arrival wins.
  assign take_new = (cand_sad < best_sad) ||
                    ((cand_sad == best_sad) && (cand_cost < best_cost));

endmodule

// File: rtl/me_best_match.sv
// Best-match tracker for one macroblock search: two-stage capture/compare of candidate SADs.
//   state  | meaning
//   IDLE   | waiting for start
//   SEARCH | accepting candidates, stage 2 committing
//   FLUSH  | committing last captured candidate
//   OUT    | result held until res_ready
module me_best_match #(
  parameter int SAD_W = me_pkg::SAD_W,
  parameter int MV_W  = me_pkg::MV_W,
  parameter int CNT_W = me_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sad_valid,
  input  logic [SAD_W-1:0]        sad,
  input  logic signed [MV_W-1:0]  mv_x,
  input  logic signed [MV_W-1:0]  mv_y,
  input  logic                    search_done,
  input  logic [SAD_W-1:0]        thresh,
  output logic                    busy,
  output logic                    early_stop,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [MV_W-1:0]  best_mv_x,
  output logic signed [MV_W-1:0]  best_mv_y,
  output logic [CNT_W-1:0]        cand_count,
  output logic                    no_cand
);

  import me_pkg::*;

  localparam int COST_W = MV_W + 1;

  me_state_e state, state_nxt;

  logic                   clear;
  logic                   accept;
  logic                   take_new;

  logic                   s1_valid;
  logic [SAD_W-1:0]       s1_sad;
  logic signed [MV_W-1:0] s1_mv_x;
  logic signed [MV_W-1:0] s1_mv_y;
  logic [COST_W-1:0]      s1_cost;
  logic [COST_W-1:0]      best_cost;

  logic [MV_W-1:0]        abs_x;
  logic [MV_W-1:0]        abs_y;
  logic [COST_W-1:0]      cand_cost;

  // The most negative value maps to its magnitude as an unsigned bit pattern.
  function automatic logic [MV_W-1:0] abs_mv(input logic signed [MV_W-1:0] v);
    logic [MV_W-1:0] u;
    u = $unsigned(v);
    return v[MV_W-1] ? (~u + 1'b1) : u;
  endfunction

  assign abs_x     = abs_mv(mv_x);
  assign abs_y     = abs_mv(mv_y);
  assign cand_cost = {1'b0, abs_x} + {1'b0, abs_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (start) begin
          clear = 1'b1;
        end else begin
          accept = sad_valid;
          if (search_done) state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: state_nxt = ST_OUT;
      ST_OUT: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  me_sad_cmp #(
    .SAD_W  (SAD_W),
    .COST_W (COST_W)
  ) u_cmp (
    .cand_sad  (s1_sad),
    .best_sad  (best_sad),
    .cand_cost (s1_cost),
    .best_cost (best_cost),
    .take_new  (take_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sad     <= '0;
      s1_mv_x    <= '0;
      s1_mv_y    <= '0;
      s1_cost    <= '0;
      best_sad   <= '1;
      best_mv_x  <= '0;
      best_mv_y  <= '0;
      best_cost  <= '1;
      cand_count <= '0;
      early_stop <= 1'b0;
    end else if (clear) begin
      s1_valid   <= 1'b0;
      best_sad   <= '1;
      best_mv_x  <= '0;
      best_mv_y  <= '0;
      best_cost  <= '1;
      cand_count <= '0;
      early_stop <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sad  <= sad;
        s1_mv_x <= mv_x;
        s1_mv_y <= mv_y;
        s1_cost <= cand_cost;
        if (cand_count != {CNT_W{1'b1}}) cand_count <= cand_count + 1'b1;
      end
      // Stage 2: fold the captured candidate into the running best.
      if (s1_valid && take_new) begin
        best_sad  <= s1_sad;
        best_mv_x <= s1_mv_x;
        best_mv_y <= s1_mv_y;
        best_cost <= s1_cost;
        if (s1_sad <= thresh) early_stop <= 1'b1;
      end
    end
  end

  assign busy      = (state == ST_SEARCH) || (state == ST_FLUSH);
  assign res_valid = (state == ST_OUT);
  assign no_cand   = res_valid && (cand_count == '0);

endmodule
